// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   IF-stage dynamic branch predictor. It uses a direct-mapped BTB with one
//   2-bit saturating counter per entry. The EX-stage resolution of the branch
//   in flight trains it one cycle later. It also keeps free-running branch and
//   mispredict counters for performance measurement.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   if_pc             : current fetch PC (looked up combinationally)
//   predict_taken     : the fetch PC hits a valid entry whose counter is T
//   predict_target    : BTB target when predicted taken, otherwise if_pc + 4
//   ex_is_branch      : EX holds a resolved conditional branch
//   ex_taken          : resolved direction
//   ex_predict_wrong  : the branch was mispredicted
//   ex_pc             : PC of the EX branch
//   ex_br_target      : computed taken target of the EX branch
//   branch_count      : resolved conditional branches since reset
//   mispredict_count  : mispredicted branches since reset
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic        ex_predict_wrong,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_br_target,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        branch_count_q, branch_count_d;
    logic [31:0]        mispredict_count_q, mispredict_count_d;

    logic [INDEX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]   if_tag, ex_tag;
    logic               if_hit, ex_hit;

    // The two low PC bits never take part in index or tag.
    logic unused_low_bits;
    assign unused_low_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[INDEX_W+1:2];
    assign if_tag = if_pc[31:INDEX_W+2];
    assign ex_idx = ex_pc[INDEX_W+1:2];
    assign ex_tag = ex_pc[31:INDEX_W+2];

    // Lookup reads only registered state, so an update to the same entry in
    // this cycle becomes visible only on the next cycle.
    always_comb begin
        if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        predict_taken  = if_hit && ctr_q[if_idx][1];
        predict_target = predict_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        ex_hit             = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

        if (ex_is_branch) begin
            branch_count_d = branch_count_q + 32'd1;
            if (ex_predict_wrong)
                mispredict_count_d = mispredict_count_q + 32'd1;

            if (ex_hit) begin
                if (ex_taken) begin
                    ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                    target_d[ex_idx] = ex_br_target;
                end else begin
                    ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                // A taken miss allocates and evicts whatever aliased there.
                // Not-taken misses are never allocated.
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_br_target;
                ctr_d[ex_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= 2'b01;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ex_is_branch, ex_taken, ex_predict_wrong;
    logic [31:0] ex_pc, ex_br_target;
    logic [31:0] branch_count, mispredict_count;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_predict_wrong (ex_predict_wrong),
        .ex_pc            (ex_pc),
        .ex_br_target     (ex_br_target),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs mid-cycle; outputs are then stable pre-edge.
    task automatic cyc(input logic r, input logic br, input logic tk, input logic wr,
                       input logic [31:0] epc, input logic [31:0] etgt, input logic [31:0] ipc);
        @(negedge clk);
        rst = r; ex_is_branch = br; ex_taken = tk; ex_predict_wrong = wr;
        ex_pc = epc; ex_br_target = etgt; if_pc = ipc;
        #1;
    endtask

    // Directed table. The expected values are the outputs seen during that
    // cycle, which are before that cycle's update lands.
    typedef struct {
        logic        br, tk, wr;
        logic [31:0] epc, etgt, ipc;
        logic        exp_tk;
        logic [31:0] exp_tgt, exp_bc, exp_mc;
    } vec_t;
    vec_t vecs[15];

    // Reference model: a plain array of entries, with the counter held as an integer 0..3
    typedef struct {
        bit          v;
        int unsigned tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;
    ent_t        m[ENTRIES];
    int unsigned m_bc, m_mc;

    function automatic int unsigned pidx(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction
    function automatic int unsigned ptag(input logic [31:0] pc);
        return pc / (ENTRIES * 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m[i].v = 0; m[i].ctr = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic model_step(input logic r, input logic br, input logic tk, input logic wr,
                              input logic [31:0] epc, input logic [31:0] etgt);
        int unsigned e;
        e = pidx(epc);
        if (r) begin
            model_reset();
        end else if (br) begin
            m_bc = m_bc + 1;
            if (wr) m_mc = m_mc + 1;
            if (m[e].v && m[e].tag == ptag(epc)) begin
                if (tk) begin
                    m[e].ctr = (m[e].ctr < 3) ? m[e].ctr + 1 : 3;
                    m[e].tgt = etgt;
                end else begin
                    m[e].ctr = (m[e].ctr > 0) ? m[e].ctr - 1 : 0;
                end
            end else if (tk) begin
                m[e].v = 1; m[e].tag = ptag(epc); m[e].tgt = etgt; m[e].ctr = 2;
            end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 15) == 0)
            p = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        else
            p = 32'($urandom_range(0, 2) * 256 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        logic        exp_tk;
        logic [31:0] exp_tgt;

        vecs[0]  = '{0, 0, 0, 32'h0,    32'h0,   32'h100,  0, 32'h104,  0, 0};
        vecs[1]  = '{1, 1, 1, 32'h100,  32'h200, 32'h100,  0, 32'h104,  0, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,    32'h0,   32'h100,  1, 32'h200,  1, 1};
        vecs[3]  = '{1, 0, 1, 32'h100,  32'h0,   32'h100,  1, 32'h200,  1, 1};
        vecs[4]  = '{1, 0, 0, 32'h100,  32'h0,   32'h100,  0, 32'h104,  2, 2};
        vecs[5]  = '{1, 1, 0, 32'h100,  32'h200, 32'h100,  0, 32'h104,  3, 2};
        vecs[6]  = '{1, 1, 0, 32'h100,  32'h200, 32'h100,  0, 32'h104,  4, 2};
        vecs[7]  = '{0, 0, 0, 32'h0,    32'h0,   32'h100,  1, 32'h200,  5, 2};
        vecs[8]  = '{0, 0, 0, 32'h0,    32'h0,   32'h1100, 0, 32'h1104, 5, 2};
        vecs[9]  = '{1, 1, 0, 32'h1100, 32'h300, 32'h1100, 0, 32'h1104, 5, 2};
        vecs[10] = '{0, 0, 0, 32'h0,    32'h0,   32'h100,  0, 32'h104,  6, 2};
        vecs[11] = '{0, 0, 0, 32'h0,    32'h0,   32'h1100, 1, 32'h300,  6, 2};
        vecs[12] = '{0, 1, 1, 32'h1100, 32'h500, 32'h1100, 1, 32'h300,  6, 2};
        vecs[13] = '{0, 0, 0, 32'h0,    32'h0,   32'h1100, 1, 32'h300,  6, 2};
        vecs[14] = '{0, 0, 0, 32'h0,    32'h0,   32'hFFFF_FFFC, 0, 32'h0, 6, 2};

        cyc(1, 0, 0, 0, 0, 0, 32'h100);
        cyc(1, 0, 0, 0, 0, 0, 32'h100);

        for (int i = 0; i < 15; i++) begin
            cyc(0, vecs[i].br, vecs[i].tk, vecs[i].wr, vecs[i].epc, vecs[i].etgt, vecs[i].ipc);
            chk($sformatf("tbl%0d_taken", i),  predict_taken,    vecs[i].exp_tk);
            chk($sformatf("tbl%0d_target", i), predict_target,   vecs[i].exp_tgt);
            chk($sformatf("tbl%0d_bcnt", i),   branch_count,     vecs[i].exp_bc);
            chk($sformatf("tbl%0d_mcnt", i),   mispredict_count, vecs[i].exp_mc);
        end

        // Reset coincident with a taken update: reset wins.
        cyc(1, 1, 1, 1, 32'h100, 32'h200, 32'h100);
        cyc(0, 0, 0, 0, 0, 0, 32'h1100);
        chk("rst_upd_taken_1100",  predict_taken,    0);
        chk("rst_upd_target_1100", predict_target,   32'h1104);
        chk("rst_upd_bcnt",        branch_count,     0);
        chk("rst_upd_mcnt",        mispredict_count, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h100);
        chk("rst_upd_taken_100",   predict_taken,    0);
        chk("rst_upd_target_100",  predict_target,   32'h104);

        // Randomized run against the reference model
        cyc(1, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        r, br, tk, wr;
            logic [31:0] epc, etgt, ipc;
            int unsigned li;
            r    = ($urandom_range(0, 199) == 0);
            br   = ($urandom_range(0, 9) < 7);
            tk   = 1'($urandom);
            wr   = 1'($urandom);
            epc  = rand_pc();
            etgt = $urandom;
            ipc  = ($urandom_range(0, 3) == 0) ? epc : rand_pc();
            cyc(r, br, tk, wr, epc, etgt, ipc);
            li      = pidx(ipc);
            exp_tk  = m[li].v && m[li].tag == ptag(ipc) && m[li].ctr >= 2;
            exp_tgt = exp_tk ? m[li].tgt : ipc + 32'd4;
            chk($sformatf("rnd%0d_taken", n),  predict_taken,    exp_tk);
            chk($sformatf("rnd%0d_target", n), predict_target,   exp_tgt);
            chk($sformatf("rnd%0d_bcnt", n),   branch_count,     m_bc);
            chk($sformatf("rnd%0d_mcnt", n),   mispredict_count, m_mc);
            model_step(r, br, tk, wr, epc, etgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage dynamic branch predictor: direct-mapped BTB, one 2-bit saturating counter per entry.
- Each cycle it supplies predict_taken and the next-fetch PC for the current fetch PC.
- Trained one cycle later by the EX-stage branch resolution outputs (taken, is_branch, predict_wrong).
- Keeps 32-bit branch and mispredict counters for performance measurement.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, minimum 2.
- INDEX_W, $clog2(ENTRIES), index width; index = pc[INDEX_W+1:2].
- TAG_W, 30-INDEX_W, tag width; tag = pc[31:INDEX_W+2].

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_pc  input  32  current fetch PC
- predict_taken  output  1  prediction for if_pc
- predict_target  output  32  predicted next PC
- ex_is_branch  input  1  EX holds a conditional branch
- ex_taken  input  1  resolved outcome from EX
- ex_predict_wrong  input  1  EX mispredict flag
- ex_pc  input  32  PC of the EX branch
- ex_br_target  input  32  computed taken target of the EX branch
- branch_count  output  32  resolved conditional branches since reset
- mispredict_count  output  32  mispredicted branches since reset

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), ctr (2).
  - ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from if_pc, zero-cycle latency:
  - hit = valid[idx] & (tag[idx] == if_pc tag).
  - predict_taken = hit & ctr[idx][1].
  - predict_target = predict_taken ? target[idx] : if_pc + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Lookup always sees pre-edge state.
  - No write-to-read bypass when ex_pc and if_pc index the same entry in the same cycle.
- Update occurs on the rising edge only when ex_is_branch=1 and rst=0. Let e = index of ex_pc.
  - Hit, ex_taken=1: ctr saturating-increment (11 stays 11); target <= ex_br_target.
  - Hit, ex_taken=0: ctr saturating-decrement (00 stays 00); target unchanged.
  - Miss, ex_taken=1: allocate. valid<=1, tag<=ex_pc tag, target<=ex_br_target, ctr<=10. Any aliased entry is replaced.
  - Miss, ex_taken=0: no change; not-taken branches are never allocated.
- ex_is_branch=0: no table change, even if ex_taken=1 or ex_predict_wrong=1.
- Counters:
  - branch_count += 1 when ex_is_branch=1.
  - mispredict_count += 1 when ex_is_branch=1 and ex_predict_wrong=1.
  - Both wrap 0xFFFFFFFF -> 0.
  - Both update on the same edge as the table.
- Reset (synchronous, any cycle, overrides a concurrent update):
  - All valid <= 0, all ctr <= 01.
  - tag/target need not be cleared.
  - branch_count = 0, mispredict_count = 0.
- Reset values of outputs:
  - predict_taken = 0 (all entries invalid).
  - predict_target = if_pc+4.
  - Both counters read 0 in the first cycle after reset.
- No FSM beyond the per-entry counter. Counter transitions are exactly:
  - 00 -> 01 -> 10 -> 11 on taken.
  - 11 -> 10 -> 01 -> 00 on not-taken.
- Low PC bits [1:0] are ignored for index and tag.

Test Plan:
- Reset, then if_pc=0x00000100 -> predict_taken=0, predict_target=0x00000104; both counters 0.
- Update ex_pc=0x100, ex_taken=1, ex_br_target=0x200, ex_is_branch=1, ex_predict_wrong=1.
  - Next cycle, if_pc=0x100 -> predict_taken=1, target=0x200.
  - branch_count=1, mispredict_count=1.
- Same entry: one not-taken update -> ctr 01, predict_taken=0. A second not-taken -> ctr 00. Then two taken updates -> ctr 10, predict_taken=1.
- Alias (ENTRIES=64): train 0x100 taken. Lookup 0x1100 (same index, different tag) -> predict_taken=0, target=0x1104. Taken update at 0x1100 with target 0x300 -> 0x100 now misses; 0x1100 predicts 0x300.
- Same-cycle lookup and update of 0x100 (first allocation):
  - Update cycle shows predict_taken=0.
  - Following cycle shows 1.
- Assert rst in the same cycle as a taken update -> entry invalid next cycle and counters 0.
- Preload branch_count=0xFFFFFFFF via 2^32-1 updates (or force) -> next branch wraps it to 0.
- ex_is_branch=0 with ex_taken=1 -> table and counters unchanged.
